// File: rtl/parity_serializer_if.sv
// Purpose: groups the serializer's load/codeword inputs and serial-line outputs.
// Latency: none (wiring only).
// Backpressure: none; the serial line is free-running once a frame starts.
// Ports: load, data_in (encoder side); ser_out, ser_valid, frame_start,
//        frame_done, busy, overrun (channel side).
interface parity_serializer_if #(
  parameter int WORD_W = 96
);
  logic              load;
  logic [WORD_W-1:0] data_in;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_start;
  logic              frame_done;
  logic              busy;
  logic              overrun;

  // master: the encoder/test side that supplies codewords and watches the line
  modport master (
    output load, data_in,
    input  ser_out, ser_valid, frame_start, frame_done, busy, overrun
  );

  // slave: the serializer itself
  modport slave (
    input  load, data_in,
    output ser_out, ser_valid, frame_start, frame_done, busy, overrun
  );
endinterface

// File: rtl/parity_serializer.sv
// Purpose: captures a codeword on a rising load and emits it MSB-first with a
//          parity bit after every GROUP_W data bits.
// Latency: first data bit one cycle after the load edge, last parity bit
//          WORD_W + WORD_W/GROUP_W cycles after it.
// Backpressure: none; load edges arriving mid-frame are dropped and flagged
//               on the sticky overrun output.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries load,
//        data_in, ser_out, ser_valid, frame_start, frame_done, busy, overrun.
module parity_serializer #(
  parameter int WORD_W  = 96,
  parameter int GROUP_W = 8,
  parameter int ODD_PAR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_serializer_if.slave   bus
);

  localparam int NGRP = WORD_W / GROUP_W;
  localparam int BW   = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(GROUP_W - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);
  localparam logic          PAR_INV  = (ODD_PAR != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
  logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [GW-1:0]     grp_cnt_q,   grp_cnt_d;
  logic              par_acc_q,   par_acc_d;
  logic              load_dly_q,  load_dly_d;
  logic              overrun_q,   overrun_d;

  logic load_edge;
  logic last_par;
  logic busy_c;
  logic ser_out_c;
  logic ser_valid_c;
  logic frame_start_c;
  logic frame_done_c;

  // Edge detect: a level that was already high before the clock is ignored.
  assign load_edge = bus.load & ~load_dly_q;

  // The final parity slot of a frame is the one cycle where a new load edge
  // is accepted without a gap instead of being flagged as an overrun.
  assign last_par  = (state_q == PAR) && (grp_cnt_q == GRP_LAST);
  assign busy_c    = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    shift_reg_d   = shift_reg_q;
    bit_cnt_d     = bit_cnt_q;
    grp_cnt_d     = grp_cnt_q;
    par_acc_d     = par_acc_q;
    load_dly_d    = bus.load;
    overrun_d     = overrun_q;
    ser_out_c     = 1'b0;
    ser_valid_c   = 1'b0;
    frame_start_c = 1'b0;
    frame_done_c  = 1'b0;

    if (load_edge && busy_c && !last_par) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (load_edge) begin
          shift_reg_d = bus.data_in;
          bit_cnt_d   = '0;
          grp_cnt_d   = '0;
          par_acc_d   = 1'b0;
          state_d     = DATA;
        end
      end

      DATA: begin
        ser_out_c     = shift_reg_q[WORD_W-1];
        ser_valid_c   = 1'b1;
        frame_start_c = (bit_cnt_q == '0) && (grp_cnt_q == '0);
        shift_reg_d   = {shift_reg_q[WORD_W-2:0], 1'b0};
        par_acc_d     = par_acc_q ^ shift_reg_q[WORD_W-1];
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = PAR;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      PAR: begin
        ser_out_c   = par_acc_q ^ PAR_INV;
        ser_valid_c = 1'b1;
        par_acc_d   = 1'b0;
        if (grp_cnt_q == GRP_LAST) begin
          frame_done_c = 1'b1;
          grp_cnt_d    = '0;
          if (load_edge) begin
            // Back-to-back frame: recapture now so bit 0 follows immediately.
            shift_reg_d = bus.data_in;
            bit_cnt_d   = '0;
            state_d     = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          grp_cnt_d = grp_cnt_q + 1'b1;
          state_d   = DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
      grp_cnt_q   <= '0;
      par_acc_q   <= 1'b0;
      load_dly_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      grp_cnt_q   <= grp_cnt_d;
      par_acc_q   <= par_acc_d;
      load_dly_q  <= load_dly_d;
      overrun_q   <= overrun_d;
    end
  end

  // Line outputs decode directly from the registered state, so an
  // asynchronous reset silences them in the same cycle.
  assign bus.ser_out     = ser_out_c;
  assign bus.ser_valid   = ser_valid_c;
  assign bus.frame_start = frame_start_c;
  assign bus.frame_done  = frame_done_c;
  assign bus.busy        = busy_c;
  assign bus.overrun     = overrun_q;

endmodule
